lock_traffic_queue: RTL

LOCK_TRAFFIC_QUEUE -- requirements
Module: lock_traffic_queue

---
 rtl/lock_traffic_queue.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/lock_traffic_queue.sv
// Lock traffic controller: debounces boat sensors, queues transit requests by
// direction and sequences one transit at a time through the lock chamber.
module lock_traffic_queue #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arrive_left,
    input  logic                       arrive_right,
    input  logic                       exit_left,
    input  logic                       exit_right,
    input  logic                       lock_ready,
    output logic                       transit_valid,
    output logic                       transit_dir,
    output logic                       status,
    output logic                       occupied,
    output logic [$clog2(DEPTH+1)-1:0] queue_count,
    output logic                       overflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned AL = 0;
    localparam int unsigned AR = 1;
    localparam int unsigned EL = 2;
    localparam int unsigned ER = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, TRANSIT, EXIT} state_e;

    state_e            state_q, state_d;
    logic [3:0][3:0]   cnt_q, cnt_d;
    logic [3:0]        evt_q, evt_d;
    logic [3:0]        raw;
    logic [DEPTH-1:0]  mem_q, mem_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              dir_q, dir_d;
    logic              pop, push_vld, push_dir, push_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign raw = {exit_right, exit_left, arrive_right, arrive_left};

    // Event fires on the sample that brings the counter to DEBOUNCE, so a
    // sensor held high saturates and never re-fires.
    always_comb begin
        cnt_d = cnt_q;
        evt_d = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!raw[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != 4'(DEBOUNCE)) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
                evt_d[i] = (cnt_q[i] == 4'(DEBOUNCE - 1));
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        dir_d         = dir_q;
        pop           = 1'b0;
        transit_valid = 1'b0;
        transit_dir   = dir_q;
        status        = 1'b0;
        occupied      = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = ISSUE;
            end
            ISSUE: begin
                transit_valid = 1'b1;
                transit_dir   = mem_q[head_q];
                if (lock_ready) begin
                    pop     = 1'b1;
                    dir_d   = mem_q[head_q];
                    state_d = TRANSIT;
                end
            end
            TRANSIT: begin
                status   = 1'b1;
                occupied = 1'b1;
                if (dir_q ? evt_q[EL] : evt_q[ER]) state_d = EXIT;
            end
            EXIT: begin
                occupied = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Left wins a simultaneous arrival; right waits one cycle in pending.
    always_comb begin
        pending_d  = pending_q;
        push_vld   = 1'b0;
        push_dir   = 1'b0;
        if (evt_q[AL]) begin
            push_vld  = 1'b1;
            pending_d = pending_q | evt_q[AR];
        end else if (pending_q) begin
            push_vld  = 1'b1;
            push_dir  = 1'b1;
            pending_d = evt_q[AR];
        end else if (evt_q[AR]) begin
            push_vld  = 1'b1;
            push_dir  = 1'b1;
        end

        push_ok    = push_vld && !((count_q == CW'(DEPTH)) && !pop);
        mem_d      = mem_q;
        tail_d     = tail_q;
        head_d     = head_q;
        overflow_d = overflow_q | (push_vld & ~push_ok);
        if (push_ok) begin
            mem_d[tail_q] = push_dir;
            tail_d        = ptr_inc(tail_q);
        end
        if (pop) head_d = ptr_inc(head_q);
        count_d = count_q + CW'(push_ok) - CW'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            evt_q      <= '0;
            mem_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            dir_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            evt_q      <= evt_d;
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            dir_q      <= dir_d;
        end
    end

    assign queue_count = count_q;
    assign overflow    = overflow_q;

endmodule
